// File: rtl/sys_defs.sv
// Shared system definitions: datapath widths, lane count, instruction type,
// the WFI encoding, and the types used by the fetch buffer.
package sys_defs;

    localparam int XLEN   = 32;
    localparam int N_WAY  = 2;
    localparam int DISP_W = $clog2(N_WAY + 1);

    typedef logic [31:0] INST;

    localparam INST WFI_INST = 32'h1050_0073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        INST             inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_WAIT,
        FS_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer and Imem.
interface fetch_buffer_if;
    import sys_defs::*;

    logic            proc2Imem_req;
    logic [XLEN-1:0] proc2Imem_addr;
    logic            Imem2proc_valid;
    INST             Imem2proc_data;

    modport master (
        output proc2Imem_req,
        output proc2Imem_addr,
        input  Imem2proc_valid,
        input  Imem2proc_data
    );

    modport slave (
        input  proc2Imem_req,
        input  proc2Imem_addr,
        output Imem2proc_valid,
        output Imem2proc_data
    );

endinterface

// File: rtl/fetch_ring.sv
// Circular instruction queue: single push, an N_WAY-wide read window starting
// at head, and a variable pop clamped to the number of valid window lanes.
module fetch_ring
    import sys_defs::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic [DISP_W-1:0]        pop_req,
    output logic [CNT_W-1:0]         count,
    output logic [N_WAY-1:0]         win_valid,
    output fetch_entry_t [N_WAY-1:0] win_entry
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] avail;
    logic [CNT_W-1:0] pop_n;
    logic [PTR_W-1:0] rd_idx;

    always_comb begin
        avail   = (count_q < CNT_W'(N_WAY)) ? count_q : CNT_W'(N_WAY);
        pop_n   = (CNT_W'(pop_req) > avail) ? avail : CNT_W'(pop_req);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain truncation
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(push);
            count_d = count_q + CNT_W'(push) - pop_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    always_comb begin
        rd_idx    = '0;
        win_valid = '0;
        win_entry = '0;
        for (int i = 0; i < N_WAY; i++) begin
            rd_idx       = head_q + PTR_W'(i);
            win_valid[i] = (CNT_W'(i) < count_q);
            win_entry[i] = win_valid[i] ? mem_q[rd_idx] : '0;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one-outstanding-request fetch control feeding a
// circular queue. Define FETCH_WFI_STOP_EN to stop fetching after a WFI.
//
// state   | meaning
// FS_IDLE | no request outstanding
// FS_WAIT | request outstanding, response will be enqueued
// FS_DROP | request outstanding across a redirect, response will be discarded
module fetch_buffer
    import sys_defs::*;
#(
    parameter  int              DEPTH    = 8,
    parameter  logic [XLEN-1:0] RESET_PC = '0,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    fetch_buffer_if.master             imem,
    input  logic                       redirect_en,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic [DISP_W-1:0]          dispatch_count,
    output logic [N_WAY-1:0][XLEN-1:0] out_PC,
    output INST  [N_WAY-1:0]           out_inst,
    output logic [N_WAY-1:0]           out_valid,
    output logic [CNT_W-1:0]           count
);

    fetch_state_t             state_q, state_d;
    logic [XLEN-1:0]          fetch_pc_q, fetch_pc_d;
    logic                     halted_q, halted_d;
    logic                     pending;
    logic                     resp;
    logic                     req;
    logic                     push;
    logic [CNT_W:0]           occupancy;
    fetch_entry_t             push_entry;
    logic [N_WAY-1:0]         win_valid;
    fetch_entry_t [N_WAY-1:0] win_entry;

    assign pending   = (state_q != FS_IDLE);
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(pending);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        push       = 1'b0;
        push_entry = '{pc: fetch_pc_q, inst: imem.Imem2proc_data};
        resp       = pending && imem.Imem2proc_valid;
        req        = !pending && !halted_q && !redirect_en &&
                     (occupancy < (CNT_W + 1)'(DEPTH));
        if (redirect_en) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            if (resp) begin
                state_d = FS_IDLE;
            end else if (pending) begin
                state_d = FS_DROP;
            end
        end else if (resp) begin
            state_d = FS_IDLE;
            if (state_q == FS_WAIT) begin
                push       = 1'b1;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
`ifdef FETCH_WFI_STOP_EN
                halted_d   = (imem.Imem2proc_data == WFI_INST);
`endif
            end
        end else if (req) begin
            state_d = FS_WAIT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
        end
    end

    assign imem.proc2Imem_req  = req;
    assign imem.proc2Imem_addr = fetch_pc_q;

    fetch_ring #(.DEPTH(DEPTH)) u_ring (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_en),
        .push       (push),
        .push_entry (push_entry),
        .pop_req    (dispatch_count),
        .count      (count),
        .win_valid  (win_valid),
        .win_entry  (win_entry)
    );

    always_comb begin
        out_PC   = '0;
        out_inst = '0;
        for (int i = 0; i < N_WAY; i++) begin
            out_PC[i]   = win_entry[i].pc;
            out_inst[i] = win_entry[i].inst;
        end
    end

    assign out_valid = win_valid;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-based reference model,
// preceded by directed boundary scenarios.
module tb_fetch_buffer;
    import sys_defs::*;

    localparam int              DEPTH    = 8;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic                       redirect_en;
    logic [XLEN-1:0]            redirect_pc;
    logic [DISP_W-1:0]          dispatch_count;
    logic [N_WAY-1:0][XLEN-1:0] out_PC;
    INST  [N_WAY-1:0]           out_inst;
    logic [N_WAY-1:0]           out_valid;
    logic [3:0]                 count;

    fetch_buffer_if bus();

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (bus),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .dispatch_count (dispatch_count),
        .out_PC         (out_PC),
        .out_inst       (out_inst),
        .out_valid      (out_valid),
        .count          (count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    fetch_entry_t    mq[$];
    logic [XLEN-1:0] m_pc;
    bit              m_pend, m_drop, m_halt;

    // memory responder
    bit              mem_busy;
    int              mem_cnt;
    INST             mem_data;
    int              lat_cfg;
    bit              rand_data;
    logic [XLEN-1:0] wfi_addr;

    // stimulus for the next cycle
    bit              t_redir, t_stray, rel_pend;
    logic [XLEN-1:0] t_rpc;
    int              t_disp;

    logic [XLEN-1:0] dut_popped[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic INST data_for(input logic [XLEN-1:0] addr);
        if (addr == wfi_addr) return WFI_INST;
        if (rand_data) return ($urandom_range(0, 15) == 0) ? WFI_INST : INST'($urandom);
        return 32'h13 + addr * 32'h20;
    endfunction

    task automatic step();
        bit                         e_req, resp, mv;
        int                         n, npop;
        INST                        md;
        logic [XLEN-1:0]            req_addr;
        logic [N_WAY-1:0]           e_val;
        logic [N_WAY-1:0][XLEN-1:0] e_pc;
        INST  [N_WAY-1:0]           e_inst;
        @(negedge clock);
        if (rel_pend) begin
            reset    = 1'b1;
            rel_pend = 1'b0;
        end
        mv = 1'b0;
        md = '0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_busy = 1'b0;
                mv       = 1'b1;
                md       = mem_data;
            end
        end
        if (t_stray) begin
            mv = 1'b1;
            md = INST'($urandom);
        end
        bus.Imem2proc_valid = mv;
        bus.Imem2proc_data  = md;
        redirect_en         = t_redir;
        redirect_pc         = t_rpc;
        dispatch_count      = DISP_W'(t_disp);
        #1;
        n      = mq.size();
        e_req  = !m_pend && !m_halt && !t_redir && (n + int'(m_pend) < DEPTH);
        e_val  = '0;
        e_pc   = '0;
        e_inst = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (i < n) begin
                e_val[i]  = 1'b1;
                e_pc[i]   = mq[i].pc;
                e_inst[i] = mq[i].inst;
            end
        end
        check("req", bus.proc2Imem_req, e_req);
        check("addr", bus.proc2Imem_addr, m_pc);
        check("count", count, n);
        check("out_valid", out_valid, e_val);
        check("out_PC", out_PC, e_pc);
        check("out_inst", out_inst, e_inst);

        npop     = (t_disp < n) ? t_disp : n;
        npop     = (npop < N_WAY) ? npop : N_WAY;
        resp     = mv && m_pend;
        req_addr = m_pc;
        if (t_redir) begin
            mq.delete();
            m_pc   = t_rpc;
            m_halt = 1'b0;
            if (resp) begin
                m_pend = 1'b0;
                m_drop = 1'b0;
            end else if (m_pend) begin
                m_drop = 1'b1;
            end
        end else begin
            for (int i = 0; i < npop; i++) begin
                dut_popped.push_back(out_PC[i]);
                void'(mq.pop_front());
            end
            if (resp) begin
                m_pend = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    mq.push_back('{pc: m_pc, inst: md});
                    m_pc = m_pc + 4;
`ifdef FETCH_WFI_STOP_EN
                    if (md == WFI_INST) m_halt = 1'b1;
`endif
                end
            end
            if (e_req) m_pend = 1'b1;
        end
        if (e_req) begin
            mem_busy = 1'b1;
            mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
            mem_data = data_for(req_addr);
        end
        t_stray = 1'b0;
    endtask

    // Reset is released inside the next step() so the model sees that cycle;
    // a stale response is injected in the first cycle after release.
    task automatic do_reset();
        @(negedge clock);
        reset               = 1'b0;
        bus.Imem2proc_valid = 1'b0;
        redirect_en         = 1'b0;
        dispatch_count      = '0;
        mq.delete();
        m_pc     = RESET_PC;
        m_pend   = 1'b0;
        m_drop   = 1'b0;
        m_halt   = 1'b0;
        mem_busy = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_pc", out_PC, 0);
        check("rst_inst", out_inst, 0);
        check("rst_req", bus.proc2Imem_req, 1);
        check("rst_addr", bus.proc2Imem_addr, RESET_PC);
        @(posedge clock);
        rel_pend = 1'b1;
        t_stray  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int              req_hits;
        logic [XLEN-1:0] first_addr;
        bus.Imem2proc_valid = 1'b0;
        bus.Imem2proc_data  = '0;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        dispatch_count = '0;
        t_redir   = 1'b0;
        t_stray   = 1'b0;
        rel_pend  = 1'b0;
        t_rpc     = '0;
        t_disp    = 0;
        lat_cfg   = 1;
        rand_data = 1'b0;
        wfi_addr  = '1;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        mem_data  = '0;

        // three responses after reset
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step();
            if (mq.size() == 3) break;
        end
        @(posedge clock); #1;
        check("d3_valid", out_valid, 2'b11);
        check("d3_pc", out_PC, {32'h4, 32'h0});
        check("d3_inst", out_inst, {32'h93, 32'h13});
        check("d3_count", count, 3);

        // response and single dispatch in the same cycle
        for (int c = 0; c < 10; c++) begin
            if (mem_busy && mem_cnt == 1) break;
            step();
        end
        t_disp = 1;
        step();
        t_disp = 0;
        @(posedge clock); #1;
        check("enq_deq_count", count, 3);
        check("enq_deq_pc", out_PC, {32'h8, 32'h4});

        // fill to DEPTH, then drain two
        do_reset();
        for (int c = 0; c < 60; c++) begin
            step();
            if (mq.size() == DEPTH) break;
        end
        for (int c = 0; c < 3; c++) step();
        @(posedge clock); #1;
        check("full_count", count, 8);
        check("full_req", bus.proc2Imem_req, 0);
        t_disp = 2;
        step();
        t_disp = 0;
        @(posedge clock); #1;
        check("refill_req", bus.proc2Imem_req, 1);
        check("refill_addr", bus.proc2Imem_addr, 32'h20);

        // redirect while the 0x8 request is outstanding
        do_reset();
        lat_cfg = 2;
        for (int c = 0; c < 30; c++) begin
            step();
            if (m_pend && m_pc == 32'h8) break;
        end
        t_redir = 1'b1;
        t_rpc   = 32'h100;
        step();
        t_redir = 1'b0;
        step();
        @(posedge clock); #1;
        check("redir_count", count, 0);
        check("redir_req", bus.proc2Imem_req, 1);
        check("redir_addr", bus.proc2Imem_addr, 32'h100);
        step();

        // stream 20 instructions through the wrap
        do_reset();
        lat_cfg = 1;
        t_disp  = 2;
        dut_popped.delete();
        for (int c = 0; c < 200; c++) begin
            step();
            if (dut_popped.size() >= 20) break;
        end
        t_disp = 0;
        check("stream_len", dut_popped.size() >= 20, 1);
        for (int i = 0; i < 20 && i < dut_popped.size(); i++) begin
            check("stream_pc", dut_popped[i], 32'(i * 4));
        end

        // WFI at 0xC
        do_reset();
        wfi_addr = 32'hC;
        for (int c = 0; c < 30; c++) begin
            step();
            if (mq.size() == 4) break;
        end
        req_hits   = 0;
        first_addr = '1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.proc2Imem_req && req_hits == 0) first_addr = bus.proc2Imem_addr;
            req_hits += int'(bus.proc2Imem_req);
        end
`ifdef FETCH_WFI_STOP_EN
        check("wfi_halt_req", req_hits, 0);
        check("wfi_halt_addr", bus.proc2Imem_addr, 32'h10);
        t_redir = 1'b1;
        t_rpc   = 32'h200;
        step();
        t_redir = 1'b0;
        step();
        check("wfi_resume_req", bus.proc2Imem_req, 1);
        check("wfi_resume_addr", bus.proc2Imem_addr, 32'h200);
`else
        check("wfi_cont_req", req_hits > 0, 1);
        check("wfi_cont_addr", first_addr, 32'h10);
`endif
        wfi_addr = '1;

        // randomized traffic
        lat_cfg   = 0;
        rand_data = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            t_disp  = int'($urandom_range(0, 3));
            t_redir = ($urandom_range(0, 19) == 0);
            t_rpc   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 199) == 0) begin
                t_redir = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end
        t_redir = 1'b0;
        t_disp  = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
